// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Contents:
//   arb_state_e   - top-level FSM states (INIT clear sweep, RUN arbitration)
//   DEF_*         - default datapath widths and register count
//   rr_next_ptr() - round-robin pointer successor, modulo the requester count
package regfile_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH = 5;
  localparam int unsigned DEF_NUM_REGS      = 32;

  // Index of the requester that follows `idx`, wrapping at `n`.
  function automatic int unsigned rr_next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection over NUM_REQ requesters.
// Default build: round-robin, search starts at ptr_i and the first valid requester wins.
// With REGFILE_WB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr_i ignored.
// Ports:
//   req_i [NUM_REQ]  - request vector
//   ptr_i [PtrW]     - round-robin start index
//   en_i             - grant enable; no grant is issued while low
//   gnt_o [NUM_REQ]  - one-hot grant (all zero when idle or disabled)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!en_i) gnt_o = '0;
  end

`else

  always_comb begin
    logic        found;
    int unsigned idx;
    found = 1'b0;
    idx   = 0;
    gnt_o = '0;
    // Walk the ring once, starting at the pointer, wrapping past the top index.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!en_i) gnt_o = '0;
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources.
// After reset, writes zero to registers 0..NUM_REGS-1 (one per cycle), then arbitrates.
// Arbitration is round-robin by default; define REGFILE_WB_ARB_FIXED_PRIO_EN for fixed
// priority (lowest index wins, no pointer register).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - per-requester handshake; ready is combinational, one-hot
//   req_dest/req_data        - packed per-requester destination and data (requester k at slice k)
//   rg_wrt_en/dest/data      - registered register-file write port
//   init_done                - high once the clear sweep has finished
//   last_grant               - index of the most recently accepted requester
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic                             rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]            rg_wrt_data,
  output logic                             init_done,
  output logic [$clog2(NUM_REQ)-1:0]       last_grant
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  arb_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     en_q, en_d;
  logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     done_q, done_d;
  logic [PtrW-1:0]          last_q, last_d;

  logic [NUM_REQ-1:0]       gnt;
  logic [PtrW-1:0]          win;
  logic [PtrW-1:0]          arb_ptr;
  logic [ADDRESS_WIDTH-1:0] win_dest;
  logic [DATA_WIDTH-1:0]    win_data;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PtrW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) ptr_d = PtrW'(rr_next_ptr(32'(win), NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Grants only in RUN, and never while reset is asserted.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (PtrW)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (arb_ptr),
    .en_i  ((state_q == RUN) && !rst),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    win = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) win = PtrW'(k);
    end
  end

  assign win_dest = req_dest[win*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign win_data = req_data[win*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    dest_d  = dest_q;
    data_d  = data_q;
    done_d  = done_q;
    last_d  = last_q;
    unique case (state_q)
      INIT: begin
        en_d   = 1'b1;
        dest_d = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + ADDRESS_WIDTH'(1);
        if (cnt_q == ADDRESS_WIDTH'(NUM_REGS - 1)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (|gnt) begin
          last_d = win;
          // x0 is hardwired zero: accept the transfer but suppress the write.
          if (win_dest != '0) begin
            en_d   = 1'b1;
            dest_d = win_dest;
            data_d = win_data;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign rg_wrt_en   = en_q;
  assign rg_wrt_dest = dest_q;
  assign rg_wrt_data = data_q;
  assign init_done   = done_q;
  assign last_grant  = last_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with default parameters (3 requesters, 32x32).
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_dest;
  logic [NR*DW-1:0] req_data;
  logic             rg_wrt_en;
  logic [AW-1:0]    rg_wrt_dest;
  logic [DW-1:0]    rg_wrt_data;
  logic             init_done;
  logic [1:0]       last_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dest    (req_dest),
    .req_data    (req_data),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_dest (rg_wrt_dest),
    .rg_wrt_data (rg_wrt_data),
    .init_done   (init_done),
    .last_grant  (last_grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] d, input logic [DW-1:0] v);
    req_dest[k*AW +: AW] = d;
    req_data[k*DW +: DW] = v;
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] d, input logic [DW-1:0] v);
    check({tag, "_en"}, 64'(rg_wrt_en), 64'(1));
    check({tag, "_dest"}, 64'(rg_wrt_dest), 64'(d));
    check({tag, "_data"}, 64'(rg_wrt_data), 64'(v));
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    req_valid = '1;
    req_dest  = '0;
    req_data  = '0;
    set_req(0, 5'd3, 32'hA0A0_0000);
    set_req(1, 5'd4, 32'hB1B1_1111);
    set_req(2, 5'd6, 32'hC2C2_2222);
    tick();
    tick();

    // Reset state, with every requester asserting valid.
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_en", 64'(rg_wrt_en), 64'(0));
    check("rst_dest", 64'(rg_wrt_dest), 64'(0));
    check("rst_data", 64'(rg_wrt_data), 64'(0));
    check("rst_done", 64'(init_done), 64'(0));
    check("rst_last", 64'(last_grant), 64'(0));

    // Clear sweep: one zero write per cycle to 0..31, no grants meanwhile.
    rst = 1'b0;
    check("init_ready0", 64'(req_ready), 64'(0));
    for (int i = 1; i <= 32; i++) begin
      tick();
      check_write("sweep", AW'(i - 1), '0);
      check("sweep_done", 64'(init_done), 64'(i == 32));
      if (i < 32) check("sweep_ready", 64'(req_ready), 64'(0));
      else        req_valid = '0;
    end
    tick();
    check("post_sweep_en", 64'(rg_wrt_en), 64'(0));
    check("post_sweep_done", 64'(init_done), 64'(1));
    check("idle_ready", 64'(req_ready), 64'(0));

    // Continuous requests from all three.
    req_valid = 3'b111;
    for (int s = 0; s < 6; s++) begin
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = s % 3;
`endif
      #1;
      check("cont_ready", 64'(req_ready), 64'(1 << w));
      tick();
      check("cont_last", 64'(last_grant), 64'(w));
      case (w)
        0:       check_write("cont", 5'd3, 32'hA0A0_0000);
        1:       check_write("cont", 5'd4, 32'hB1B1_1111);
        default: check_write("cont", 5'd6, 32'hC2C2_2222);
      endcase
    end
    req_valid = '0;
    tick();
    check("cont_idle_en", 64'(rg_wrt_en), 64'(0));

    // Single requester 1.
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    check("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    check_write("single", 5'd5, 32'hDEAD_BEEF);
    check("single_last", 64'(last_grant), 64'(1));
    #1;
    check("single_ready_after", 64'(req_ready), 64'(0));
    // No transfer: enable drops, dest/data hold.
    tick();
    check("hold_en", 64'(rg_wrt_en), 64'(0));
    check("hold_dest", 64'(rg_wrt_dest), 64'(5));
    check("hold_data", 64'(rg_wrt_data), 64'(32'hDEAD_BEEF));
    check("hold_last", 64'(last_grant), 64'(1));

    // Requester 2 targets x0 while requester 0 also waits; pointer is at 2.
    set_req(2, 5'd0, 32'h0000_1234);
    set_req(0, 5'd9, 32'h0000_0055);
    req_valid = 3'b101;
    #1;
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
    check("wrap_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b100;
    check_write("wrap0", 5'd9, 32'h55);
    check("wrap_last0", 64'(last_grant), 64'(0));
    #1;
    check("x0_ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0;
    check("x0_en", 64'(rg_wrt_en), 64'(0));
    check("x0_last", 64'(last_grant), 64'(2));
`else
    check("x0_ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = 3'b001;
    check("x0_en", 64'(rg_wrt_en), 64'(0));
    check("x0_last", 64'(last_grant), 64'(2));
    #1;
    check("wrap_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    check_write("wrap0", 5'd9, 32'h55);
    check("wrap_last0", 64'(last_grant), 64'(0));
`endif
    tick();
    check("wrap_idle_en", 64'(rg_wrt_en), 64'(0));

    // Reset after ten sweep writes restarts the sweep from register 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_write("sweep2a", AW'(i - 1), '0);
    end
    rst = 1'b1;
    req_valid = 3'b111;
    #1;
    check("midrst_ready", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    req_valid = '0;
    check("midrst_en", 64'(rg_wrt_en), 64'(0));
    check("midrst_dest", 64'(rg_wrt_dest), 64'(0));
    check("midrst_done", 64'(init_done), 64'(0));
    check("midrst_last", 64'(last_grant), 64'(0));
    for (int i = 1; i <= 32; i++) begin
      tick();
      check_write("sweep2b", AW'(i - 1), '0);
      check("sweep2b_done", 64'(init_done), 64'(i == 32));
    end
    tick();
    check("sweep2_end_en", 64'(rg_wrt_en), 64'(0));
    check("sweep2_end_done", 64'(init_done), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources, e.g. ALU, load unit and MUL/DIV.
- After reset, first runs a clear sweep that writes zero to every register, then arbitrates round-robin.
- Drives the register file's write-enable, write-destination and write-data inputs from registers.
- Sits between the pipeline writeback stage(s) and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, register data width.
- ADDRESS_WIDTH, 5, register address width.
- NUM_REGS, 32, registers swept during init (≤ 2^ADDRESS_WIDTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept (grant), combinational.
- req_dest  in  NUM_REQ*ADDRESS_WIDTH  packed destinations; requester k at slice k.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- rg_wrt_en  out  1  register-file write enable, registered.
- rg_wrt_dest  out  ADDRESS_WIDTH  register-file write address, registered.
- rg_wrt_data  out  DATA_WIDTH  register-file write data, registered.
- init_done  out  1  high once the clear sweep is complete.
- last_grant  out  $clog2(NUM_REQ)  index of the most recently accepted requester.

Behaviour:
- Reset (rst=1 at posedge):
  - state<=INIT, sweep counter<=0, rr pointer<=0.
  - Outputs: rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, init_done=0, last_grant=0.
  - req_ready=0 while rst is high.
  - Reset mid-sweep or mid-run restarts the sweep from register 0.
- State INIT:
  - req_ready all 0.
  - Each cycle: rg_wrt_en<=1, rg_wrt_dest<=counter, rg_wrt_data<=0, counter++.
  - After issuing address NUM_REGS-1, go to RUN.
  - init_done goes to 1 in the first RUN cycle; the sweep takes exactly NUM_REGS cycles.
- State RUN:
  - Handshake: a transfer occurs for requester k when req_valid[k] && req_ready[k].
  - At most one req_ready bit is high per cycle, and only for a valid requester.
  - req_ready never depends on data or dest.
  - Arbitration is round-robin. Search starts at index rr_ptr. The first valid requester wins.
  - On a transfer, rr_ptr<=winner+1 (mod NUM_REQ) and last_grant<=winner.
  - Latency: transfer at cycle N -> rg_wrt_en=1 with that dest/data during cycle N+1.
  - No transfer -> rg_wrt_en<=0; dest and data hold their previous values.
  - Destination 0 (x0): the transfer is accepted (ready=1, pointer advances), but rg_wrt_en<=0. x0 is never written after init.
  - Fairness: under continuous requests, each requester is granted once every NUM_REQ cycles. Worst-case wait is NUM_REQ-1 cycles.
  - Requesters must hold valid, dest and data stable until accepted. The block does not buffer.
  - No requests valid -> all ready=0 and rr_ptr unchanged.
- RUN is terminal until the next rst.

Optional Feature:
- Macro: REGFILE_WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index always wins. rr_ptr is not instantiated. last_grant still updates.
- Undefined (default): round-robin exactly as above.
- The sweep, latency and x0 rules are identical in both modes.

Decomposition:
- Package regfile_arb_pkg:
  - state enum arb_state_e {INIT, RUN}.
  - Default width constants DATA_WIDTH=32, ADDRESS_WIDTH=5, NUM_REGS=32.
  - Helper function for round-robin next-pointer.
- One sub-module, rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req vector, pointer, enable. Output: one-hot grant.
  - The macro selects the fixed-priority path inside it.
- Top level holds the FSM, sweep counter and output registers.

Test Plan:
- Reset, then idle: rg_wrt_en=1 for exactly 32 cycles, dest 0..31, data 0. Then init_done=1 and rg_wrt_en=0. req_ready stays 0 throughout, even with all req_valid=1.
- After init, only req 1 valid with dest=5, data=0xDEADBEEF: ready[1]=1 at cycle N. Cycle N+1: rg_wrt_en=1, dest=5, data=0xDEADBEEF, last_grant=1.
- All three valid and held continuously after init: grant order 0,1,2,0,1,2 with one write per cycle. Under REGFILE_WB_ARB_FIXED_PRIO_EN: requester 0 every cycle.
- Req 2 valid with dest=0, data=0x1234: ready[2]=1 and the pointer advances, but rg_wrt_en stays 0 the next cycle.
- Assert rst at sweep count 10 for one cycle: the sweep restarts at dest=0 and completes 32 cycles later. init_done remains 0 until then.
- Req 0 valid at the same time as a transfer from req 2 that wraps the pointer: the next grant goes to 0, with no skipped or duplicate grant.
